// File: rtl/game_tick_sequencer.sv
// game_tick_sequencer: per-frame update scheduler for the Flappy Bird datapath.
// Runs one PHYSICS->COLLIDE->SCORE->COMMIT handshake sequence per (divided) vblank tick.
//
// state   | meaning
// IDLE    | waiting for a frame tick
// PHYSICS | bird motion update; jump_req meaningful
// COLLIDE | pipe / ground collision test
// SCORE   | score update
// COMMIT  | publish new frame state
module game_tick_sequencer #(
  parameter int TICK_LINE   = 481,
  parameter int START_LINE  = 0,
  parameter int TICK_DIV    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        up,
  input  logic        pause,
  input  logic        clr_ovr,
  input  logic        phase_done,
  output logic        phase_valid,
  output logic [1:0]  phase,
  output logic        jump_req,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic [7:0]  drop_cnt
);

  localparam logic [9:0] TICK_V   = 10'(TICK_LINE);
  localparam logic [9:0] START_V  = 10'(START_LINE);
  localparam logic [3:0] DIV_LAST = 4'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PHYSICS, S_COLLIDE, S_SCORE, S_COMMIT
  } state_t;

  state_t                 state_q, state_d;
  logic                   tick_cond_q, tick_cond_d;
  logic                   start_cond_q, start_cond_d;
  logic [SYNC_STAGES-1:0] up_sync_q, up_sync_d;
  logic                   up_prev_q, up_prev_d;
  logic                   jump_pend_q, jump_pend_d;
  logic [3:0]             div_cnt_q, div_cnt_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;

  logic tick_ev, start_ev, up_edge, active, abort, advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cond_q  <= 1'b0;
      start_cond_q <= 1'b0;
      up_sync_q    <= '0;
      up_prev_q    <= 1'b0;
      jump_pend_q  <= 1'b0;
      div_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      tick_cond_q  <= tick_cond_d;
      start_cond_q <= start_cond_d;
      up_sync_q    <= up_sync_d;
      up_prev_q    <= up_prev_d;
      jump_pend_q  <= jump_pend_d;
      div_cnt_q    <= div_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    tick_cond_d  = (hCount == 10'd0) && (vCount == TICK_V);
    start_cond_d = (hCount == 10'd0) && (vCount == START_V);
    // Counters may park on a value; only the first cycle of the match counts.
    tick_ev      = tick_cond_d & ~tick_cond_q;
    start_ev     = start_cond_d & ~start_cond_q;

    up_sync_d[0] = up;
    for (int i = 1; i < SYNC_STAGES; i++) up_sync_d[i] = up_sync_q[i-1];
    up_prev_d = up_sync_q[SYNC_STAGES-1];
    up_edge   = up_sync_q[SYNC_STAGES-1] & ~up_prev_q;

    active  = (state_q != S_IDLE);
    abort   = start_ev & active;
    advance = active & phase_done & ~abort;

    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    div_cnt_d   = div_cnt_q;

    if (tick_ev) div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;

    if (abort) begin
      state_d = S_IDLE;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (!active) begin
      if (tick_ev && (div_cnt_q == 4'd0) && !pause) state_d = S_PHYSICS;
    end else if (advance) begin
      unique case (state_q)
        S_PHYSICS: state_d = S_COLLIDE;
        S_COLLIDE: state_d = S_SCORE;
        S_SCORE:   state_d = S_COMMIT;
        S_COMMIT: begin
          state_d     = S_IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
        default:   state_d = S_IDLE;
      endcase
    end

    overrun_d   = abort | (overrun_q & ~clr_ovr);
    // A fresh press landing on the PHYSICS handoff must not be lost.
    jump_pend_d = up_edge | (jump_pend_q & ~(advance && state_q == S_PHYSICS));
  end

  always_comb begin
    unique case (state_q)
      S_PHYSICS: phase = 2'd0;
      S_COLLIDE: phase = 2'd1;
      S_SCORE:   phase = 2'd2;
      S_COMMIT:  phase = 2'd3;
      default:   phase = 2'd0;
    endcase
  end

  assign phase_valid = active;
  assign busy        = active;
  assign jump_req    = jump_pend_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
